// File: rtl/mem_wb_if.sv
// Bundles the MEM/WB stage datapath so the stage and its upstream driver
// share one port list; clk and reset stay outside as plain ports.
interface mem_wb_if #(
  parameter int len_data   = 32,
  parameter int num_bits   = 5,
  parameter int depth      = 64,
  parameter int len_wb_bus = 2
);
  logic                     in_valid;
  logic [len_data-1:0]      in_addr_mem;
  logic [len_data-1:0]      write_data;
  logic [8:0]               memory_bus;
  logic [len_wb_bus-1:0]    in_writeBack_bus;
  logic [num_bits-1:0]      in_write_reg;
  logic                     zero_flag;
  logic [len_data-1:0]      in_pc_branch;
  logic                     halt_flag_m;
  logic [$clog2(depth)-1:0] debug_addr;

  logic                     stall;
  logic                     pc_src;
  logic [len_data-1:0]      out_pc_branch;
  logic [len_data-1:0]      read_data;
  logic [len_wb_bus-1:0]    out_writeBack_bus;
  logic [len_data-1:0]      out_addr_mem;
  logic [num_bits-1:0]      out_write_reg;
  logic                     out_valid;
  logic                     misalign;
  logic                     out_halt_flag_m;
  logic [len_data-1:0]      debug_data;

  modport master (
    output in_valid, in_addr_mem, write_data, memory_bus, in_writeBack_bus,
           in_write_reg, zero_flag, in_pc_branch, halt_flag_m, debug_addr,
    input  stall, pc_src, out_pc_branch, read_data, out_writeBack_bus,
           out_addr_mem, out_write_reg, out_valid, misalign, out_halt_flag_m,
           debug_data
  );

  modport slave (
    input  in_valid, in_addr_mem, write_data, memory_bus, in_writeBack_bus,
           in_write_reg, zero_flag, in_pc_branch, halt_flag_m, debug_addr,
    output stall, pc_src, out_pc_branch, read_data, out_writeBack_bus,
           out_addr_mem, out_write_reg, out_valid, misalign, out_halt_flag_m,
           debug_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: word-addressed data memory with byte/halfword
// lanes, fixed multi-cycle access latency, branch resolution and WB registers.
module mem_wb_stage #(
  parameter int len_data   = 32,
  parameter int num_bits   = 5,
  parameter int depth      = 64,
  parameter int mem_lat    = 2,
  parameter int len_wb_bus = 2
) (
  input logic     clk,
  input logic     reset,
  mem_wb_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(mem_lat + 1);
  localparam bit multi_cycle = (mem_lat > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // NOTE: data memory is deliberately never reset; it starts at zero and keeps its contents across reset.
  logic [len_data-1:0] r_mem [depth] = '{default: '0};

  state_t                r_state, w_state_nxt;
  logic [cw-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_stall, w_complete;

  logic                  w_mem_write, w_mem_read, w_branch, w_unsigned;
  logic                  w_lh, w_lb, w_sh, w_sb, w_bne, w_memop;
  logic                  w_byte_op, w_half_op, w_word_op, w_misalign;
  logic [aw-1:0]         w_idx;
  logic [1:0]            w_off;
  logic [len_data-1:0]   w_word, w_load, w_store;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr;

  logic                  r_valid, r_misalign, r_halt;
  logic [len_data-1:0]   r_read_data, r_addr;
  logic [len_wb_bus-1:0] r_wb;
  logic [num_bits-1:0]   r_write_reg;

  assign w_mem_write = bus.memory_bus[0];
  assign w_mem_read  = bus.memory_bus[1];
  assign w_branch    = bus.memory_bus[2];
  assign w_unsigned  = bus.memory_bus[3];
  assign w_lh        = bus.memory_bus[4];
  assign w_lb        = bus.memory_bus[5];
  assign w_sh        = bus.memory_bus[6];
  assign w_sb        = bus.memory_bus[7];
  assign w_bne       = bus.memory_bus[8];
  assign w_memop     = w_mem_read | w_mem_write;

  // Addresses above the memory span wrap onto it.
  assign w_idx         = bus.in_addr_mem[aw+1:2];
  assign w_off         = bus.in_addr_mem[1:0];
  assign w_unused_addr = ^bus.in_addr_mem[len_data-1:aw+2];
  assign w_word        = r_mem[w_idx];

  assign w_byte_op  = w_lb | w_sb;
  assign w_half_op  = w_lh | w_sh;
  assign w_word_op  = ~(w_byte_op | w_half_op);
  assign w_misalign = w_memop & ((w_half_op & w_off[0]) |
                                 (w_word_op & (w_off != 2'b00)));

  assign bus.pc_src        = bus.in_valid & w_branch &
                             (w_bne ? ~bus.zero_flag : bus.zero_flag);
  assign bus.out_pc_branch = bus.in_pc_branch;
  assign bus.debug_data    = r_mem[bus.debug_addr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_byte = w_word[{w_off, 3'b000} +: 8];
    w_half = w_word[{w_off[1], 4'b0000} +: 16];
    w_load = w_word;
    if (w_lb)
      w_load = {{(len_data-8){~w_unsigned & w_byte[7]}}, w_byte};
    else if (w_lh)
      w_load = {{(len_data-16){~w_unsigned & w_half[15]}}, w_half};

    w_store = bus.write_data;
    if (w_sb) begin
      w_store = w_word;
      w_store[{w_off, 3'b000} +: 8] = bus.write_data[7:0];
    end else if (w_sh) begin
      w_store = w_word;
      w_store[{w_off[1], 4'b0000} +: 16] = bus.write_data[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (w_memop && !w_misalign && multi_cycle) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = cw'(mem_lat - 1);
            w_stall     = 1'b1;
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      BUSY: begin
        if (r_cnt == cw'(1)) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.stall = w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reset has priority, so a store pending in BUSY is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_complete && w_mem_write && !w_misalign)
      r_mem[w_idx] <= w_store;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_misalign  <= 1'b0;
      r_halt      <= 1'b0;
      r_read_data <= '0;
      r_addr      <= '0;
      r_wb        <= '0;
      r_write_reg <= '0;
    end else begin
      r_valid <= w_complete;
      if (w_complete) begin
        r_misalign  <= w_misalign;
        r_halt      <= bus.halt_flag_m;
        r_addr      <= bus.in_addr_mem;
        r_write_reg <= bus.in_write_reg;
        r_wb        <= w_misalign ? '0 : bus.in_writeBack_bus;
        r_read_data <= w_misalign ? '0 : w_load;
      end else begin
        r_wb <= '0;
      end
    end
  end

  assign bus.out_valid         = r_valid;
  assign bus.misalign          = r_misalign;
  assign bus.out_halt_flag_m   = r_halt;
  assign bus.read_data         = r_read_data;
  assign bus.out_addr_mem      = r_addr;
  assign bus.out_writeBack_bus = r_wb;
  assign bus.out_write_reg     = r_write_reg;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a scoreboard
// queue of expected write-back results popped whenever out_valid is seen.
module tb_mem_wb_stage;
  localparam logic [8:0] MW  = 9'h001, MR = 9'h002, BR = 9'h004, UNS = 9'h008;
  localparam logic [8:0] LH  = 9'h010, LB = 9'h020, SH = 9'h040, SB  = 9'h080;
  localparam logic [8:0] BNE = 9'h100;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [1:0]  wb;
    bit          chk_rd;
    logic [31:0] rdata;
    bit          mis;
    bit          halt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [31:0] model_mem [64];

  always #5 clk = ~clk;

  mem_wb_if #(.len_data(32), .num_bits(5), .depth(64), .len_wb_bus(2)) mif();

  mem_wb_stage #(.len_data(32), .num_bits(5), .depth(64), .mem_lat(2),
                 .len_wb_bus(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif.slave)
  );

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (mif.out_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_valid=1 with no expected entry, addr=%h", mif.out_addr_mem);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_checks++;
          if (mif.out_addr_mem !== e.addr) begin
            n_fail++; $display("FAIL sb_addr: got %h want %h", mif.out_addr_mem, e.addr);
          end
          n_checks++;
          if (mif.out_write_reg !== e.rd) begin
            n_fail++; $display("FAIL sb_rd: got %0d want %0d", mif.out_write_reg, e.rd);
          end
          n_checks++;
          if (mif.out_writeBack_bus !== e.wb) begin
            n_fail++; $display("FAIL sb_wb @%h: got %b want %b", e.addr, mif.out_writeBack_bus, e.wb);
          end
          n_checks++;
          if (mif.misalign !== e.mis) begin
            n_fail++; $display("FAIL sb_misalign @%h: got %b want %b", e.addr, mif.misalign, e.mis);
          end
          n_checks++;
          if (mif.out_halt_flag_m !== e.halt) begin
            n_fail++; $display("FAIL sb_halt: got %b want %b", mif.out_halt_flag_m, e.halt);
          end
          if (e.chk_rd) begin
            n_checks++;
            if (mif.read_data !== e.rdata) begin
              n_fail++; $display("FAIL sb_read_data @%h: got %h want %h", e.addr, mif.read_data, e.rdata);
            end
          end
        end
      end else begin
        n_checks++;
        if (mif.out_writeBack_bus !== 2'b00) begin
          n_fail++; $display("FAIL idle_wb: got %b want 00", mif.out_writeBack_bus);
        end
      end
    end
  end

  task automatic drive_idle();
    mif.in_valid = 1'b0;
    mif.in_addr_mem = '0;
    mif.write_data = '0;
    mif.memory_bus = '0;
    mif.in_writeBack_bus = '0;
    mif.in_write_reg = '0;
    mif.zero_flag = 1'b0;
    mif.in_pc_branch = '0;
    mif.halt_flag_m = 1'b0;
  endtask

  // Issues one instruction, counts stall cycles and waits for its completion edge.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [8:0] mbus, input logic [1:0] wb,
                        input logic [4:0] rd, input bit halt, input int exp_stalls,
                        input bit chk_rd, input logic [31:0] exp_rd, input bit exp_mis,
                        input string name);
    exp_t e;
    int   stalls;
    bit   done;
    @(negedge clk);
    mif.in_valid = 1'b1;
    mif.in_addr_mem = addr;
    mif.write_data = wdata;
    mif.memory_bus = mbus;
    mif.in_writeBack_bus = wb;
    mif.in_write_reg = rd;
    mif.halt_flag_m = halt;
    e.addr = addr; e.rd = rd; e.wb = exp_mis ? 2'b00 : wb; e.chk_rd = chk_rd;
    e.rdata = exp_rd; e.mis = exp_mis; e.halt = halt;
    sb_q.push_back(e);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      if (mif.stall) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s_timeout: stall still 1 after 16 cycles", name);
    end
    n_checks++;
    if (stalls != exp_stalls) begin
      n_fail++; $display("FAIL %s_stalls: got %0d want %0d", name, stalls, exp_stalls);
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic check_dbg(input logic [5:0] idx, input logic [31:0] exp, input string name);
    mif.debug_addr = idx;
    #1;
    n_checks++;
    if (mif.debug_data !== exp) begin
      n_fail++; $display("FAIL %s: debug_data[%0d] got %h want %h", name, idx, mif.debug_data, exp);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    mif.debug_addr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", mif.out_valid); end
    n_checks++;
    if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", mif.stall); end
    n_checks++;
    if (mif.out_writeBack_bus !== 2'b00) begin n_fail++; $display("FAIL rst_wb: got %b want 00", mif.out_writeBack_bus); end
    n_checks++;
    if (mif.misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", mif.misalign); end
    n_checks++;
    if (mif.out_addr_mem !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mif.out_addr_mem); end
    n_checks++;
    if (mif.read_data !== 32'h0) begin n_fail++; $display("FAIL rst_read_data: got %h want 0", mif.read_data); end
    check_dbg(6'd0, 32'h0, "rst_mem0");
    check_dbg(6'd63, 32'h0, "rst_mem63");
    reset = 1'b0;
  endtask

  task automatic test_store_word();
    run_op(32'h8, 32'hDEADBEEF, MW, 2'b00, 5'd0, 1'b0, 1, 1'b0, 32'h0, 1'b0, "sw");
    check_dbg(6'd2, 32'hDEADBEEF, "sw_mem");
  endtask

  task automatic test_byte_half();
    run_op(32'h9, 32'h0000007F, MW | SB, 2'b00, 5'd0, 1'b0, 1, 1'b0, 32'h0, 1'b0, "sb");
    check_dbg(6'd2, 32'hDEAD7FEF, "sb_mem");
    run_op(32'hB, 32'h0, MR | LB, 2'b11, 5'd3, 1'b0, 1, 1'b1, 32'hFFFFFFDE, 1'b0, "lb");
    run_op(32'hB, 32'h0, MR | LB | UNS, 2'b11, 5'd4, 1'b0, 1, 1'b1, 32'h000000DE, 1'b0, "lbu");
    run_op(32'hA, 32'h0, MR | LH, 2'b11, 5'd5, 1'b0, 1, 1'b1, 32'hFFFFDEAD, 1'b0, "lh");
    run_op(32'h8, 32'h0, MR | LH | UNS, 2'b01, 5'd6, 1'b0, 1, 1'b1, 32'h00007FEF, 1'b0, "lhu");
    run_op(32'h8, 32'h0, MR, 2'b11, 5'd7, 1'b0, 1, 1'b1, 32'hDEAD7FEF, 1'b0, "lw");
  endtask

  task automatic test_misalign();
    run_op(32'h9, 32'h0, MR | LH, 2'b11, 5'd8, 1'b0, 0, 1'b1, 32'h0, 1'b1, "lh_mis");
    run_op(32'hA, 32'h12345678, MW, 2'b00, 5'd0, 1'b0, 0, 1'b0, 32'h0, 1'b1, "sw_mis");
    run_op(32'hB, 32'h0000AAAA, MW | SH, 2'b00, 5'd0, 1'b0, 0, 1'b0, 32'h0, 1'b1, "sh_mis");
    check_dbg(6'd2, 32'hDEAD7FEF, "mis_mem_unchanged");
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    mif.in_valid = 1'b1;
    mif.in_addr_mem = 32'h0;
    mif.write_data = 32'h1;
    mif.memory_bus = MW;
    #1;
    n_checks++;
    if (mif.stall !== 1'b1) begin n_fail++; $display("FAIL rbusy_stall_start: got %b want 1", mif.stall); end
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rbusy_valid: got %b want 0", mif.out_valid); end
    n_checks++;
    if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL rbusy_stall: got %b want 0", mif.stall); end
    check_dbg(6'd0, 32'h0, "rbusy_mem0");
    check_dbg(6'd2, 32'hDEAD7FEF, "rbusy_mem2_kept");
  endtask

  task automatic test_branch();
    @(negedge clk);
    mif.in_pc_branch = 32'h0000_1234;
    mif.memory_bus = BR | BNE;
    mif.zero_flag = 1'b0;
    mif.in_valid = 1'b1;
    #1;
    n_checks++;
    if (mif.pc_src !== 1'b1) begin n_fail++; $display("FAIL br_bne_taken: got %b want 1", mif.pc_src); end
    n_checks++;
    if (mif.out_pc_branch !== 32'h0000_1234) begin n_fail++; $display("FAIL br_target: got %h want 00001234", mif.out_pc_branch); end
    mif.zero_flag = 1'b1;
    #1;
    n_checks++;
    if (mif.pc_src !== 1'b0) begin n_fail++; $display("FAIL br_bne_not: got %b want 0", mif.pc_src); end
    mif.memory_bus = BR;
    #1;
    n_checks++;
    if (mif.pc_src !== 1'b1) begin n_fail++; $display("FAIL br_beq_taken: got %b want 1", mif.pc_src); end
    mif.in_valid = 1'b0;
    #1;
    n_checks++;
    if (mif.pc_src !== 1'b0) begin n_fail++; $display("FAIL br_invalid: got %b want 0", mif.pc_src); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_mem[2] = 32'hDEAD7FEF;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      model_mem[16 + i] = v;
      run_op(32'h40 + 32'(4 * i), v, MW, 2'b00, 5'd0, 1'b0, 1, 1'b0, 32'h0, 1'b0, "b2b_sw");
    end
    for (int i = 0; i < 4; i++)
      run_op(32'h40 + 32'(4 * i), 32'h0, MR, 2'b11, 5'(10 + i), 1'b0, 1, 1'b1,
             model_mem[16 + i], 1'b0, "b2b_lw");
    v = 32'hCAFE_F00D;
    model_mem[4] = v;
    run_op(32'h110, v, MW, 2'b00, 5'd0, 1'b0, 1, 1'b0, 32'h0, 1'b0, "wrap_sw");
    check_dbg(6'd4, model_mem[4], "wrap_mem");
    run_op(32'h55, 32'h0, 9'h000, 2'b10, 5'd7, 1'b1, 0, 1'b0, 32'h0, 1'b0, "alu_halt");
  endtask

  task automatic test_drain();
    int waited;
    waited = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d expected results never produced", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_half();
    test_misalign();
    test_reset_busy();
    test_branch();
    test_back_to_back();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter len_data, default 32, data/address width (multiple of 8, >=32).
REQ-002 SHALL have parameter num_bits, default 5, register-index width.
REQ-003 SHALL have parameter depth, default 64, data-memory words (power of 2).
REQ-004 SHALL have parameter mem_lat, default 2, memory access cycles (>=1).
REQ-005 SHALL have parameter len_wb_bus, default 2, write-back control width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  stage input holds a valid instruction.
- in_addr_mem  in  len_data  ALU result / byte address.
- write_data  in  len_data  store data.
- memory_bus  in  9  [0]MemWrite [1]MemRead [2]Branch [3]unsigned [4]LH [5]LB [6]SH [7]SB [8]BranchNotEqual.
- in_writeBack_bus  in  len_wb_bus  write-back control.
- in_write_reg  in  num_bits  destination register.
- zero_flag  in  1  ALU zero.
- in_pc_branch  in  len_data  branch target.
- halt_flag_m  in  1  halt marker.
- debug_addr  in  $clog2(depth)  debug word index.
- stall  out  1  upstream must hold inputs.
- pc_src  out  1  branch taken.
- out_pc_branch  out  len_data  branch target.
- read_data  out  len_data  extended load data.
- out_writeBack_bus  out  len_wb_bus  registered WB control.
- out_addr_mem  out  len_data  registered address.
- out_write_reg  out  num_bits  registered destination.
- out_valid  out  1  WB outputs valid.
- misalign  out  1  registered alignment fault.
- out_halt_flag_m  out  1  registered halt.
- debug_data  out  len_data  combinational memory word at debug_addr.

Function
REQ-007 pc_src SHALL be combinational: in_valid & Branch & (BranchNotEqual ? ~zero_flag : zero_flag); out_pc_branch = in_pc_branch.
REQ-008 Word index SHALL be in_addr_mem[$clog2(depth)+1:2]; higher bits ignored (wrap).
REQ-009 FSM states IDLE, BUSY; memop = MemRead|MemWrite.
REQ-010 IDLE, in_valid & memop & aligned & mem_lat>1: go BUSY, load counter mem_lat-1, stall=1 same cycle.
REQ-011 BUSY: stall=1, counter decrements each cycle; at counter==1 stall=0, access completes at that edge, return IDLE.
REQ-012 mem_lat==1 or non-memop or misaligned: complete in 1 cycle, stall=0.
REQ-013 Completion edge SHALL register all outputs and set out_valid=1; other cycles out_valid=0, out_writeBack_bus=0.
REQ-014 Stores SHALL write at completion edge only: SB byte lane addr[1:0]; SH halfword lane addr[1]; else full word; other lanes unchanged.
REQ-015 Loads: LB byte lane addr[1:0], LH halfword lane addr[1], zero-extended if unsigned else sign-extended; else full word.
REQ-016 Misaligned = (LH|SH)&addr[0], or word op & addr[1:0]!=0: no write, misalign=1, out_writeBack_bus=0, read_data=0, out_valid=1.
REQ-017 out_halt_flag_m SHALL register halt_flag_m at completion.
REQ-018 in_valid=0: no write, out_valid=0, state stays IDLE.

Reset
REQ-019 reset at clk edge: state IDLE, counter 0, all registered outputs 0; stall=0 next cycle.
REQ-020 reset while BUSY SHALL abort: pending store discarded.
REQ-021 Memory contents zero at time 0, unaffected by reset.

Verification
- mem_lat=2, SW 0xDEADBEEF addr 0x8 -> stall 1 cycle, then out_valid=1; debug_addr=2 reads 0xDEADBEEF.
- SB 0x7F addr 0x9 over 0xDEADBEEF -> word 0xDEAD7FEF; LB signed addr 0xB -> 0xFFFFFFDE; LBU -> 0x000000DE.
- LH addr 0xA signed -> 0xFFFFDEAD; LH addr 0x9 -> misalign=1, WB bus 0, memory unchanged.
- reset during BUSY of SW 0x1 addr 0x0 -> word 0 remains 0, out_valid 0, stall 0.
- Branch=1, BNE=1, zero=0, in_valid=1 -> pc_src=1; zero=1 -> 0; in_valid=0 -> 0.
